// File: rtl/mux_pkg.sv
// Shared select encodings and default data width for the 4-way mux block.
package mux_pkg;

    localparam int DEFAULT_WIDTH = 16;

    localparam logic [1:0] SEL_A = 2'b00;
    localparam logic [1:0] SEL_B = 2'b01;
    localparam logic [1:0] SEL_C = 2'b10;
    localparam logic [1:0] SEL_D = 2'b11;

endpackage

// File: rtl/mux_4way_core.sv
// Purely combinational 4:1 word selector; an unknown select drives zeros.
module mux_4way_core
    import mux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        case (sel)
            SEL_A:   y = a;
            SEL_B:   y = b;
            SEL_C:   y = c;
            SEL_D:   y = d;
            // X/Z select in simulation falls through to zeros
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/mux_4way_16.sv
// 4-way mux with a combinational output and an enable-gated registered output plus valid.
module mux_4way_16
    import mux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic [WIDTH-1:0] D,
    input  logic [1:0]       SEL,
    input  logic             EN,
    input  logic             VALID_IN,
    output logic [WIDTH-1:0] OUT_COMB,
    output logic [WIDTH-1:0] OUT,
    output logic             VALID_OUT
);

    logic [WIDTH-1:0] sel_data;
    logic [WIDTH-1:0] out_p1_d;
    logic [WIDTH-1:0] out_p1_q;
    logic             vld_p1_d;
    logic             vld_p1_q;

    mux_4way_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a   (A),
        .b   (B),
        .c   (C),
        .d   (D),
        .sel (SEL),
        .y   (sel_data)
    );

    assign OUT_COMB = sel_data;

    always_comb begin
        out_p1_d = out_p1_q;
        vld_p1_d = vld_p1_q;
        if (EN) begin
            out_p1_d = sel_data;
            vld_p1_d = VALID_IN;
        end
    end

    // stage p1: output register, cleared immediately by RST
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out_p1_q <= '0;
            vld_p1_q <= 1'b0;
        end else begin
            out_p1_q <= out_p1_d;
            vld_p1_q <= vld_p1_d;
        end
    end

    assign OUT       = out_p1_q;
    assign VALID_OUT = vld_p1_q;

endmodule

// File: tb/tb_mux_4way_16.sv
// Self-checking bench for mux_4way_16: directed scenarios then randomized run against a model.
module tb_mux_4way_16;

    logic        CLK = 1'b0;
    logic        RST;
    logic [15:0] A, B, C, D;
    logic [1:0]  SEL;
    logic        EN;
    logic        VALID_IN;
    logic [15:0] OUT_COMB;
    logic [15:0] OUT;
    logic        VALID_OUT;

    int checks   = 0;
    int failures = 0;

    logic [15:0] m_out;
    logic        m_vld;

    mux_4way_16 #(.WIDTH(16)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .A         (A),
        .B         (B),
        .C         (C),
        .D         (D),
        .SEL       (SEL),
        .EN        (EN),
        .VALID_IN  (VALID_IN),
        .OUT_COMB  (OUT_COMB),
        .OUT       (OUT),
        .VALID_OUT (VALID_OUT)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] pick(input logic [1:0] s);
        logic [15:0] words [4];
        words[0] = A;
        words[1] = B;
        words[2] = C;
        words[3] = D;
        return words[s];
    endfunction

    // One clock: model follows the rising edge, returns at the following falling edge.
    task automatic tick();
        @(posedge CLK);
        if (!RST && EN) begin
            m_out = pick(SEL);
            m_vld = VALID_IN;
        end
        @(negedge CLK);
    endtask

    task automatic check_regs(input string tag);
        check_eq({tag, "_out"}, {16'h0, OUT}, {16'h0, m_out});
        check_eq({tag, "_vld"}, {31'h0, VALID_OUT}, {31'h0, m_vld});
    endtask

    initial begin
        RST = 1'b1;
        A = 16'h0001; B = 16'h0002; C = 16'h0004; D = 16'h0008;
        SEL = 2'd0; EN = 1'b1; VALID_IN = 1'b1;
        m_out = 16'h0; m_vld = 1'b0;
        #1;
        check_eq("reset_out", {16'h0, OUT}, 32'h0);
        check_eq("reset_vld", {31'h0, VALID_OUT}, 32'h0);
        check_eq("reset_comb", {16'h0, OUT_COMB}, 32'h0001);
        tick();
        check_eq("reset_held_out", {16'h0, OUT}, 32'h0);
        RST = 1'b0;

        // walk the select one per cycle
        for (int s = 0; s < 4; s++) begin
            SEL = 2'(s);
            #1;
            check_eq("walk_comb", {16'h0, OUT_COMB}, 32'h1 << s);
            tick();
            check_eq("walk_out", {16'h0, OUT}, 32'h1 << s);
            check_eq("walk_vld", {31'h0, VALID_OUT}, 32'h1);
        end

        // hold with EN low
        SEL = 2'd2;
        tick();
        check_eq("hold_pre", {16'h0, OUT}, 32'h0004);
        EN = 1'b0; SEL = 2'd3;
        #1;
        check_eq("hold_comb", {16'h0, OUT_COMB}, 32'h0008);
        tick();
        check_eq("hold_out", {16'h0, OUT}, 32'h0004);
        tick();
        check_eq("hold_out2", {16'h0, OUT}, 32'h0004);
        EN = 1'b1;
        tick();
        check_eq("hold_release", {16'h0, OUT}, 32'h0008);

        // asynchronous reset between edges
        #2;
        RST = 1'b1;
        m_out = 16'h0; m_vld = 1'b0;
        #1;
        check_eq("arst_out", {16'h0, OUT}, 32'h0);
        check_eq("arst_vld", {31'h0, VALID_OUT}, 32'h0);
        check_eq("arst_comb", {16'h0, OUT_COMB}, 32'h0008);
        tick();
        check_eq("arst_held", {16'h0, OUT}, 32'h0);
        #2;
        RST = 1'b0; EN = 1'b0;
        tick();
        check_eq("arst_noen_out", {16'h0, OUT}, 32'h0);
        check_eq("arst_noen_vld", {31'h0, VALID_OUT}, 32'h0);
        EN = 1'b1;
        tick();
        check_eq("arst_recover_out", {16'h0, OUT}, 32'h0008);
        check_eq("arst_recover_vld", {31'h0, VALID_OUT}, 32'h1);

        // valid tracking
        VALID_IN = 1'b0; SEL = 2'd1;
        tick();
        check_eq("vld_low_out", {16'h0, OUT}, 32'h0002);
        check_eq("vld_low_vld", {31'h0, VALID_OUT}, 32'h0);
        VALID_IN = 1'b1;
        tick();
        check_eq("vld_high_vld", {31'h0, VALID_OUT}, 32'h1);

        // same-cycle change of select and data
        A = 16'hAAAA; B = 16'h5555; C = 16'hFFFF; D = 16'h0000; SEL = 2'd2;
        tick();
        check_eq("same_cycle_out", {16'h0, OUT}, 32'hFFFF);

        // randomized run with occasional async reset pulses
        for (int i = 0; i < 1000; i++) begin
            A = 16'($urandom); B = 16'($urandom);
            C = 16'($urandom); D = 16'($urandom);
            SEL = 2'($urandom_range(0, 3));
            EN = 1'($urandom_range(0, 3) != 0);
            VALID_IN = 1'($urandom);
            #1;
            check_eq("rnd_comb", {16'h0, OUT_COMB}, {16'h0, pick(SEL)});
            if ($urandom_range(0, 49) == 0) begin
                RST = 1'b1;
                m_out = 16'h0; m_vld = 1'b0;
                #1;
                check_regs("rnd_arst");
                check_eq("rnd_arst_comb", {16'h0, OUT_COMB}, {16'h0, pick(SEL)});
                RST = 1'b0;
            end
            tick();
            check_regs("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
